pwm_gate_monitor: RTL and testbench

Receive-side monitor for the inverter gate-drive pair. It samples the two PWM driver signals after they leave the FPGA on GPIO and are looped back, or are taken from the gate-driver board's feedback pins. For each channel it measures period and high time. It also measures the dead time between the channels and raises sticky faults for shoot-through (overlap), dead-time violation and stalled carrier. It sits in the top level beside the PWM controller, in the `clk_50` domain, and feeds the fault-handling and debug logic.

---
 rtl/pwm_gate_monitor.sv | 167 ++++++++++++++++
 tb/tb_pwm_gate_monitor.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gate_monitor.sv
// Receive-side monitor for the inverter gate-drive pair: per-channel period/high-time
// measurement, dead-time measurement, and sticky overlap / dead-time / stall faults.
//
// Per-channel FSM states:
//   state | meaning
//   IDLE  | no reference rise yet (after reset or after a stall)
//   ARMED | one rise seen, the first full period is being measured
//   RUN   | measuring continuously, every rise strobes a result
module pwm_gate_monitor #(
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned MIN_DEAD = 50
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             drv_1_in,
    input  logic             drv_2_in,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] period_1,
    output logic [CNT_W-1:0] period_2,
    output logic [CNT_W-1:0] high_1,
    output logic [CNT_W-1:0] high_2,
    output logic             valid_1,
    output logic             valid_2,
    output logic [CNT_W-1:0] dead_time,
    output logic             overlap_fault,
    output logic             dead_fault,
    output logic             stall_1,
    output logic             stall_2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } ch_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_DEAD_C = CNT_W'(MIN_DEAD);

    logic [1:0]       sync_meta;
    logic [1:0]       s;
    logic [1:0]       s_d;
    logic [1:0]       rise;
    logic [1:0]       fall;

    ch_state_t        state_q [2];
    ch_state_t        state_d [2];
    logic [1:0]       strobe;
    logic [1:0]       stall_set;

    logic [CNT_W-1:0] run_cnt [2];
    logic [CNT_W-1:0] hi_cnt  [2];
    logic [CNT_W-1:0] per_q   [2];
    logic [CNT_W-1:0] high_q  [2];
    logic [1:0]       valid_q;
    logic [1:0]       stall_q;

    logic [CNT_W-1:0] gap_cnt;
    logic             gap_armed;
    logic [CNT_W-1:0] dead_q;
    logic             overlap_q;
    logic             dead_fault_q;
    logic             overlap_set;
    logic             dead_set;

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    assign overlap_set = &s;
    assign dead_set    = (|rise) && gap_armed && (gap_cnt < MIN_DEAD_C);

    // A rise always wins over a coincident saturation so the edge is never lost.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i]   = state_q[i];
            strobe[i]    = 1'b0;
            stall_set[i] = 1'b0;
            if (rise[i]) begin
                strobe[i]  = (state_q[i] != IDLE);
                state_d[i] = (state_q[i] == IDLE) ? ARMED : RUN;
            end else if (run_cnt[i] == CNT_MAX) begin
                stall_set[i] = 1'b1;
                state_d[i]   = IDLE;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            sync_meta    <= '0;
            s            <= '0;
            s_d          <= '0;
            gap_cnt      <= '0;
            gap_armed    <= 1'b0;
            dead_q       <= '0;
            overlap_q    <= 1'b0;
            dead_fault_q <= 1'b0;
            valid_q      <= '0;
            stall_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                run_cnt[i] <= '0;
                hi_cnt[i]  <= '0;
                per_q[i]   <= '0;
                high_q[i]  <= '0;
            end
        end else begin
            sync_meta <= {drv_2_in, drv_1_in};
            s         <= sync_meta;
            s_d       <= s;
            valid_q   <= strobe;

            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];

                if (rise[i])
                    run_cnt[i] <= '0;
                else if (run_cnt[i] != CNT_MAX)
                    run_cnt[i] <= run_cnt[i] + CNT_ONE;

                if (rise[i])
                    hi_cnt[i] <= CNT_ONE;
                else if (s[i] && hi_cnt[i] != CNT_MAX)
                    hi_cnt[i] <= hi_cnt[i] + CNT_ONE;

                if (strobe[i]) begin
                    per_q[i]  <= (run_cnt[i] == CNT_MAX) ? CNT_MAX : run_cnt[i] + CNT_ONE;
                    high_q[i] <= hi_cnt[i];
                end

                if (rise[i])
                    stall_q[i] <= 1'b0;
                else if (stall_set[i])
                    stall_q[i] <= 1'b1;
            end

            if (|s)
                gap_cnt <= '0;
            else if (gap_cnt != CNT_MAX)
                gap_cnt <= gap_cnt + CNT_ONE;

            if (|fall)
                gap_armed <= 1'b1;

            // Simultaneous rises collapse into a single latch of the same gap.
            if ((|rise) && gap_armed)
                dead_q <= gap_cnt;

            overlap_q    <= overlap_set | (overlap_q & ~fault_clr);
            dead_fault_q <= dead_set | (dead_fault_q & ~fault_clr);
        end
    end

    assign period_1      = per_q[0];
    assign period_2      = per_q[1];
    assign high_1        = high_q[0];
    assign high_2        = high_q[1];
    assign valid_1       = valid_q[0];
    assign valid_2       = valid_q[1];
    assign stall_1       = stall_q[0];
    assign stall_2       = stall_q[1];
    assign dead_time     = dead_q;
    assign overlap_fault = overlap_q;
    assign dead_fault    = dead_fault_q;

endmodule

// File: tb/tb_pwm_gate_monitor.sv
// Self-checking bench for pwm_gate_monitor: a cycle-time model of the drive waveforms
// pushes expected (period, high) pairs; a negedge monitor pops them on each strobe.
module tb_pwm_gate_monitor;

    localparam int W = 10;

    logic         clk_50 = 1'b0;
    logic         rst;
    logic         drv_1_in;
    logic         drv_2_in;
    logic         fault_clr;
    logic [W-1:0] period_1;
    logic [W-1:0] period_2;
    logic [W-1:0] high_1;
    logic [W-1:0] high_2;
    logic         valid_1;
    logic         valid_2;
    logic [W-1:0] dead_time;
    logic         overlap_fault;
    logic         dead_fault;
    logic         stall_1;
    logic         stall_2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [2*W-1:0] q1 [$];
    logic [2*W-1:0] q2 [$];
    logic [2*W-1:0] e1;
    logic [2*W-1:0] e2;
    logic           arm1, arm2;
    int             rise_t1, rise_t2, high_t1, high_t2;

    pwm_gate_monitor #(.CNT_W(W), .MIN_DEAD(50)) dut (
        .clk_50        (clk_50),
        .rst           (rst),
        .drv_1_in      (drv_1_in),
        .drv_2_in      (drv_2_in),
        .fault_clr     (fault_clr),
        .period_1      (period_1),
        .period_2      (period_2),
        .high_1        (high_1),
        .high_2        (high_2),
        .valid_1       (valid_1),
        .valid_2       (valid_2),
        .dead_time     (dead_time),
        .overlap_fault (overlap_fault),
        .dead_fault    (dead_fault),
        .stall_1       (stall_1),
        .stall_2       (stall_2)
    );

    always #10 clk_50 = ~clk_50;

    // Scoreboard consumer: every strobe must match the oldest expected measurement.
    always @(negedge clk_50) begin
        if (valid_1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL strobe_1 unexpected: period=%0d high=%0d, expected no strobe", period_1, high_1);
            end else begin
                e1 = q1.pop_front();
                if ({period_1, high_1} !== e1) begin
                    errors++;
                    $display("FAIL strobe_1 period=%0d high=%0d, expected period=%0d high=%0d",
                             period_1, high_1, e1[2*W-1:W], e1[W-1:0]);
                end
            end
        end
        if (valid_2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL strobe_2 unexpected: period=%0d high=%0d, expected no strobe", period_2, high_2);
            end else begin
                e2 = q2.pop_front();
                if ({period_2, high_2} !== e2) begin
                    errors++;
                    $display("FAIL strobe_2 period=%0d high=%0d, expected period=%0d high=%0d",
                             period_2, high_2, e2[2*W-1:W], e2[W-1:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50);
            cyc++;
        end
        #1;
    endtask

    task automatic set1(input logic v);
        if (v && !drv_1_in) begin
            if (arm1) q1.push_back({W'(cyc - rise_t1), W'(high_t1)});
            arm1    = 1'b1;
            rise_t1 = cyc;
        end else if (!v && drv_1_in) begin
            high_t1 = cyc - rise_t1;
        end
        drv_1_in = v;
    endtask

    task automatic set2(input logic v);
        if (v && !drv_2_in) begin
            if (arm2) q2.push_back({W'(cyc - rise_t2), W'(high_t2)});
            arm2    = 1'b1;
            rise_t2 = cyc;
        end else if (!v && drv_2_in) begin
            high_t2 = cyc - rise_t2;
        end
        drv_2_in = v;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        drv_1_in  = 1'b0;
        drv_2_in  = 1'b0;
        fault_clr = 1'b0;
        tick(3);
        rst = 1'b0;
        q1.delete();
        q2.delete();
        arm1 = 1'b0;
        arm2 = 1'b0;
    endtask

    task automatic pair_cycle(input int g12, input int g21);
        set1(1'b1); tick(140); set1(1'b0); tick(g12);
        set2(1'b1); tick(140); set2(1'b0); tick(g21);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({period_1, period_2, high_1, high_2, dead_time} !== '0) begin
            errors++;
            $display("FAIL reset_meas got p1=%0d p2=%0d h1=%0d h2=%0d dt=%0d, expected all 0",
                     period_1, period_2, high_1, high_2, dead_time);
        end
        checks++;
        if ({valid_1, valid_2, overlap_fault, dead_fault, stall_1, stall_2} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b, expected 000000",
                     {valid_1, valid_2, overlap_fault, dead_fault, stall_1, stall_2});
        end
    endtask

    task automatic test_period_high();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set1(1'b1); tick(400); set1(1'b0); tick(600);
        end
        // 1-cycle pulse, then one more rise to report its high time
        set1(1'b1); tick(1); set1(1'b0); tick(99);
        set1(1'b1); tick(1); set1(1'b0); tick(10);
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL period_missing_strobes got %0d pending, expected 0", q1.size());
        end
        checks++;
        if (stall_1 !== 1'b0) begin
            errors++;
            $display("FAIL period_stall_1 got %b, expected 0", stall_1);
        end
    endtask

    task automatic test_dead_time();
        do_reset();
        repeat (3) pair_cycle(60, 60);
        checks++;
        if (dead_time !== 10'd60 || dead_fault !== 1'b0) begin
            errors++;
            $display("FAIL dead_legal got dt=%0d fault=%b, expected dt=60 fault=0", dead_time, dead_fault);
        end
        pair_cycle(49, 60);
        checks++;
        if (dead_time !== 10'd49 || dead_fault !== 1'b1) begin
            errors++;
            $display("FAIL dead_short got dt=%0d fault=%b, expected dt=49 fault=1", dead_time, dead_fault);
        end
        repeat (2) pair_cycle(60, 60);
        checks++;
        if (dead_time !== 10'd60 || dead_fault !== 1'b1) begin
            errors++;
            $display("FAIL dead_sticky got dt=%0d fault=%b, expected dt=60 fault=1", dead_time, dead_fault);
        end
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        checks++;
        if (dead_fault !== 1'b0 || overlap_fault !== 1'b0) begin
            errors++;
            $display("FAIL dead_clear got dead=%b overlap=%b, expected 0 0", dead_fault, overlap_fault);
        end
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL dead_missing_strobes got %0d/%0d pending, expected 0/0", q1.size(), q2.size());
        end
    endtask

    task automatic test_overlap();
        do_reset();
        set1(1'b1); tick(100);
        checks++;
        if (overlap_fault !== 1'b0) begin
            errors++;
            $display("FAIL overlap_pre got %b, expected 0", overlap_fault);
        end
        set2(1'b1); tick(4);
        checks++;
        if (overlap_fault !== 1'b1) begin
            errors++;
            $display("FAIL overlap_set got %b, expected 1", overlap_fault);
        end
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        checks++;
        if (overlap_fault !== 1'b1) begin
            errors++;
            $display("FAIL overlap_set_wins got %b, expected 1", overlap_fault);
        end
        set1(1'b0); tick(5);
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        checks++;
        if (overlap_fault !== 1'b0) begin
            errors++;
            $display("FAIL overlap_clear got %b, expected 0", overlap_fault);
        end
        set2(1'b0); tick(10);
    endtask

    task automatic test_stall();
        do_reset();
        set2(1'b1); tick(50); set2(1'b0); tick(970);
        checks++;
        if (stall_2 !== 1'b0) begin
            errors++;
            $display("FAIL stall_early got %b, expected 0", stall_2);
        end
        tick(80);
        checks++;
        if (stall_2 !== 1'b1) begin
            errors++;
            $display("FAIL stall_set got %b, expected 1", stall_2);
        end
        arm2 = 1'b0;
        set2(1'b1); tick(5);
        checks++;
        if (stall_2 !== 1'b0) begin
            errors++;
            $display("FAIL stall_rearm got %b, expected 0", stall_2);
        end
        tick(45); set2(1'b0); tick(50);
        set2(1'b1); tick(20); set2(1'b0); tick(10);
        checks++;
        if (q2.size() != 0 || period_2 !== 10'd100) begin
            errors++;
            $display("FAIL stall_period got period=%0d pending=%0d, expected 100 pending 0", period_2, q2.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set1(1'b1); tick(100); set1(1'b0); tick(100);
        set1(1'b1); tick(50);
        rst = 1'b1; tick(1); rst = 1'b0;
        checks++;
        if ({period_1, high_1, dead_time, valid_1, overlap_fault, dead_fault, stall_1} !== '0) begin
            errors++;
            $display("FAIL rstmid_zero got p=%0d h=%0d dt=%0d v=%b ov=%b df=%b st=%b, expected all 0",
                     period_1, high_1, dead_time, valid_1, overlap_fault, dead_fault, stall_1);
        end
        // drive is still high, so the reset synchronizer sees a fresh first rise now
        q1.delete();
        arm1    = 1'b1;
        rise_t1 = cyc;
        tick(80); set1(1'b0); tick(120);
        set1(1'b1); tick(10); set1(1'b0); tick(10);
        checks++;
        if (q1.size() != 0 || period_1 !== 10'd200) begin
            errors++;
            $display("FAIL rstmid_period got period=%0d pending=%0d, expected 200 pending 0", period_1, q1.size());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set1(1'b1); tick(50); set1(1'b0); tick(70);
        set1(1'b1); set2(1'b1); tick(5);
        checks++;
        if (overlap_fault !== 1'b1) begin
            errors++;
            $display("FAIL simul_overlap got %b, expected 1", overlap_fault);
        end
        checks++;
        if (dead_time !== 10'd70 || dead_fault !== 1'b0) begin
            errors++;
            $display("FAIL simul_dead got dt=%0d fault=%b, expected dt=70 fault=0", dead_time, dead_fault);
        end
        set1(1'b0); set2(1'b0); tick(20);
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL simul_strobes got %0d/%0d pending, expected 0/0", q1.size(), q2.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        drv_1_in  = 1'b0;
        drv_2_in  = 1'b0;
        fault_clr = 1'b0;
        arm1      = 1'b0;
        arm2      = 1'b0;
        rise_t1   = 0;
        rise_t2   = 0;
        high_t1   = 0;
        high_t2   = 0;
        test_reset();
        test_period_high();
        test_dead_time();
        test_overlap();
        test_stall();
        test_reset_mid();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
